timer_counter: RTL and testbench

//  Memory-mapped programmable down-counter. One instance per timer slot (TC0 at
//  0x7F00-0x7F0B, TC1 at 0x7F10-0x7F1B). Sits directly downstream of the system

---
 rtl/timer_counter.sv | 147 ++++++++++++++
 tb/tb_timer_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with CTRL/PRESET/COUNT registers,
// one-shot / auto-reload modes and a maskable level interrupt.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         ctrl_r;
    logic [CNT_W-1:0]   preset_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               irq_flag_r;
    logic               irq_flag_nxt_s;
    logic               en_clr_s;
    logic               wr_ctrl_s;
    logic               wr_preset_s;
    logic [31:0]        dout_s;
    logic               addr_unused_s;

    assign wr_ctrl_s     = WE && (Addr[3:2] == 2'b00);
    assign wr_preset_s   = WE && (Addr[3:2] == 2'b01);
    assign addr_unused_s = ^{Addr[31:4], Addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, count and interrupt-flag decisions; transitions use the pre-edge EN
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        en_clr_s       = 1'b0;
        if (wr_ctrl_s || wr_preset_s) begin
            irq_flag_nxt_s = 1'b0;
        end else begin
            irq_flag_nxt_s = irq_flag_r;
        end
        case (state_r)
            IDLE: begin
                if (ctrl_r[0]) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = CNT;
            end
            CNT: begin
                if (!ctrl_r[0]) begin
                    state_nxt_s = IDLE;
                end else if (count_r > CNT_W'(1)) begin
                    count_nxt_s = count_r - CNT_W'(1);
                end else begin
                    // Expiry sets the flag even if software writes on the same edge
                    count_nxt_s    = CNT_W'(0);
                    irq_flag_nxt_s = 1'b1;
                    state_nxt_s    = INT;
                end
            end
            INT: begin
                if (ctrl_r[2:1] == 2'b01) begin
                    irq_flag_nxt_s = 1'b0;
                    state_nxt_s    = LOAD;
                end else begin
                    en_clr_s    = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // CTRL register; a software write wins over the FSM clearing EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= 4'h0;
        end else if (wr_ctrl_s) begin
            ctrl_r <= Din[3:0];
        end else if (en_clr_s) begin
            ctrl_r[0] <= 1'b0;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // PRESET register; only consumed at the next LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_r <= CNT_W'(0);
        end else if (wr_preset_s) begin
            preset_r <= Din[CNT_W-1:0];
        end else begin
            preset_r <= preset_r;
        end
    end

    // COUNT and interrupt flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r    <= CNT_W'(0);
            irq_flag_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            irq_flag_r <= irq_flag_nxt_s;
        end
    end

    // Read mux, zero-extending the counter-width registers
    always_comb begin
        dout_s = 32'd0;
        case (Addr[3:2])
            2'b00:   dout_s[3:0]       = ctrl_r;
            2'b01:   dout_s[CNT_W-1:0] = preset_r;
            2'b10:   dout_s[CNT_W-1:0] = count_r;
            default: dout_s            = 32'd0;
        endcase
    end

    assign Dout = dout_s;
    assign IRQ  = irq_flag_r & ctrl_r[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: one task per scenario,
// expected values hand-derived from the register and FSM timing.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int pass_cnt;
    int total_cnt;

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (addr),
        .WE    (we),
        .Din   (din),
        .Dout  (dout),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        din  = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        for (int a = 0; a < 3; a++) begin
            rd(32'(a * 4), d);
            total_cnt++;
            if (d !== 32'd0) $display("FAIL reset_reg%0d got %h exp %h", a, d, 32'd0);
            else pass_cnt++;
        end
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq got %b exp %b", irq, 1'b0);
        else pass_cnt++;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic [31:0] exp_c [6] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        logic        exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus_write(32'h4, 32'd3);
        bus_write(32'h0, 32'h9);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            rd(32'h8, d);
            total_cnt++;
            if (d !== exp_c[i]) $display("FAIL oneshot_count_e%0d got %0d exp %0d", i + 1, d, exp_c[i]);
            else pass_cnt++;
            total_cnt++;
            if (irq !== exp_i[i]) $display("FAIL oneshot_irq_e%0d got %b exp %b", i + 1, irq, exp_i[i]);
            else pass_cnt++;
        end
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'h8) $display("FAIL oneshot_ctrl got %h exp %h", d, 32'h8);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_hold got %b exp %b", irq, 1'b1);
        else pass_cnt++;
        bus_write(32'h0, 32'h0);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_clear got %b exp %b", irq, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        bus_write(32'h4, 32'd2);
        bus_write(32'h0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            total_cnt++;
            if (irq !== ((k % 4) == 0)) $display("FAIL reload_irq_e%0d got %b exp %b", k, irq, ((k % 4) == 0));
            else pass_cnt++;
        end
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'hB) $display("FAIL reload_ctrl got %h exp %h", d, 32'hB);
        else pass_cnt++;
        bus_write(32'h0, 32'h0);
        tick(3);
    endtask

    task automatic test_freeze();
        logic [31:0] d;
        bus_write(32'h4, 32'd10);
        bus_write(32'h0, 32'h1);
        tick(5);
        bus_write(32'h0, 32'h0);
        tick(3);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd6) $display("FAIL freeze_count got %0d exp %0d", d, 32'd6);
        else pass_cnt++;
        bus_write(32'h0, 32'h1);
        tick(2);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd10) $display("FAIL freeze_reload got %0d exp %0d", d, 32'd10);
        else pass_cnt++;
        tick(1);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd9) $display("FAIL freeze_resume got %0d exp %0d", d, 32'd9);
        else pass_cnt++;
    endtask

    task automatic test_masked();
        logic [31:0] d;
        bus_write(32'h0, 32'h0);
        bus_write(32'h4, 32'd1);
        bus_write(32'h0, 32'h1);
        tick(3);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL masked_irq got %b exp %b", irq, 1'b0);
        else pass_cnt++;
        tick(1);
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL masked_en_clr got %h exp %h", d, 32'h0);
        else pass_cnt++;
        bus_write(32'h0, 32'h8);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL masked_flag_clr got %b exp %b", irq, 1'b0);
        else pass_cnt++;
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'h8) $display("FAIL masked_ctrl got %h exp %h", d, 32'h8);
        else pass_cnt++;
    endtask

    task automatic test_preset_zero();
        logic [31:0] d;
        bus_write(32'h4, 32'd0);
        bus_write(32'h0, 32'h9);
        tick(2);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL zero_irq_early got %b exp %b", irq, 1'b0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL zero_irq got %b exp %b", irq, 1'b1);
        else pass_cnt++;
        bus_write(32'h0, 32'h0);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL zero_count got %0d exp %0d", d, 32'd0);
        else pass_cnt++;
    endtask

    task automatic test_override();
        logic [31:0] d;
        bus_write(32'h4, 32'd1);
        bus_write(32'h0, 32'h1);
        tick(3);
        bus_write(32'h0, 32'h1);
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL override_ctrl got %h exp %h", d, 32'h1);
        else pass_cnt++;
        bus_write(32'h4, 32'd5);
        tick(1);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd5) $display("FAIL override_load got %0d exp %0d", d, 32'd5);
        else pass_cnt++;
        bus_write(32'h0, 32'h0);
    endtask

    task automatic test_ro_regs();
        logic [31:0] d;
        bus_write(32'h8, 32'hFFFF);
        bus_write(32'hC, 32'hFFFF);
        rd(32'h8, d);
        total_cnt++;
        if (d !== 32'd4) $display("FAIL ro_count got %0d exp %0d", d, 32'd4);
        else pass_cnt++;
        rd(32'hC, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL ro_reserved got %h exp %h", d, 32'd0);
        else pass_cnt++;
        rd(32'h7F14, d);
        total_cnt++;
        if (d !== 32'd5) $display("FAIL ro_preset_alias got %0d exp %0d", d, 32'd5);
        else pass_cnt++;
        bus_write(32'h0, 32'hFFFF_FFF0);
        rd(32'h0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL ro_ctrl_high got %h exp %h", d, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        bus_write(32'h4, 32'd1);
        bus_write(32'h0, 32'h9);
        tick(3);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL midrst_irq_pre got %b exp %b", irq, 1'b1);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL midrst_irq got %b exp %b", irq, 1'b0);
        else pass_cnt++;
        for (int a = 0; a < 3; a++) begin
            rd(32'(a * 4), d);
            total_cnt++;
            if (d !== 32'd0) $display("FAIL midrst_reg%0d got %h exp %h", a, d, 32'd0);
            else pass_cnt++;
        end
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        we        = 1'b0;
        addr      = 32'd0;
        din       = 32'd0;
        #1;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_freeze();
        test_masked();
        test_preset_zero();
        test_override();
        test_ro_regs();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
